// File: rtl/vga_timing_if.sv
// Signal bundle between the VGA timing generator and its consumer.
// There is no valid/ready handshake here: restart is a level sampled on
// every rising clk edge, and every other signal is a registered output that
// is valid on every cycle once reset has been released.
interface vga_timing_if;
    logic        restart;       // synchronous frame restart request
    logic [31:0] hPixel;        // horizontal position 0..H_TOTAL-1
    logic [31:0] line;          // vertical position 0..V_TOTAL-1
    logic        video_active;  // inside the visible area
    logic        hSync;         // horizontal sync, asserted at SYNC_POL
    logic        vSync;         // vertical sync, asserted at SYNC_POL
    logic        frame_start;   // one-clk pulse on the first clk of pixel (0,0)
    logic        pix_en;        // one-clk strobe per pixel period

    // Timing generator side
    modport master (
        input  restart,
        output hPixel, line, video_active, hSync, vSync, frame_start, pix_en
    );

    // Display / pixel pipeline side
    modport slave (
        output restart,
        input  hPixel, line, video_active, hSync, vSync, frame_start, pix_en
    );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator. A clock divider produces one tick per pixel
// period; horizontal and vertical counters advance on that tick. All outputs
// are registered decodes of the counter state seen before each clk edge, so
// they trail the counters by exactly one clk and always agree with each other.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CLK_DIV  = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    vga_timing_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One spare count of headroom so every boundary (including a sync end
    // that coincides with the total) is representable.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int DW = $clog2(CLK_DIV + 1);

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;

    logic tick;
    logic h_wrap;
    logic v_wrap;
    logic in_active;
    logic h_sync_on;
    logic v_sync_on;
    logic first_clk_of_frame;

    // Decodes of the current counter state; these feed both the counter
    // update and the registered outputs.
    assign tick               = (div_cnt == DIV_LAST);
    assign h_wrap             = (h_count == H_LAST);
    assign v_wrap             = (v_count == V_LAST);
    assign in_active          = (h_count < H_ACT_END) && (v_count < V_ACT_END);
    assign h_sync_on          = (h_count >= H_SYNC_BEG) && (h_count < H_SYNC_END);
    assign v_sync_on          = (v_count >= V_SYNC_BEG) && (v_count < V_SYNC_END);
    // Pixel (0,0) lasts CLK_DIV clks; only its first clk has the divider at 0.
    assign first_clk_of_frame = (h_count == '0) && (v_count == '0) && (div_cnt == '0);

    // Divider and raster counters; restart overrides tick and wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            h_count <= '0;
            v_count <= '0;
        end else if (bus.restart) begin
            div_cnt <= '0;
            h_count <= '0;
            v_count <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                if (h_wrap) begin
                    h_count <= '0;
                    v_count <= v_wrap ? '0 : v_count + 1'b1;
                end else begin
                    h_count <= h_count + 1'b1;
                end
            end
        end
    end

    // Registered outputs decoded from the pre-edge counter state. frame_start
    // is held off while restart is sampled high so that holding restart gives
    // a single pulse on the first edge after it is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.hPixel       <= '0;
            bus.line         <= '0;
            bus.video_active <= 1'b0;
            bus.hSync        <= ~SYNC_POL;
            bus.vSync        <= ~SYNC_POL;
            bus.frame_start  <= 1'b0;
            bus.pix_en       <= 1'b0;
        end else begin
            bus.hPixel       <= 32'(h_count);
            bus.line         <= 32'(v_count);
            bus.video_active <= in_active;
            bus.hSync        <= h_sync_on ? SYNC_POL : ~SYNC_POL;
            bus.vSync        <= v_sync_on ? SYNC_POL : ~SYNC_POL;
            bus.frame_start  <= first_clk_of_frame && !bus.restart;
            bus.pix_en       <= tick;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: one instance with default timing, one small-raster
// instance with CLK_DIV=3, and one small-raster instance with CLK_DIV=1 and
// active-high sync. Outputs are compared every cycle against an
// elapsed-time reference model, plus hand-written vectors and sequences.
module tb_vga_timing;

    typedef struct packed {
        logic [31:0] hp;
        logic [31:0] ln;
        logic        va;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        pe;
    } obs_t;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit pol;
        int div;
    } cfg_t;

    typedef struct {
        string name;
        int    k;
        obs_t  exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    cfg_t cfg [3];
    obs_t act [3];
    int   k_cnt [3];

    vga_timing_if if_def ();
    vga_timing_if if_b ();
    vga_timing_if if_c ();

    vga_timing u_def (.clk(clk), .reset_n(reset_n), .bus(if_def));

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .CLK_DIV(3)
    ) u_b (.clk(clk), .reset_n(reset_n), .bus(if_b));

    vga_timing #(
        .H_ACTIVE(6), .H_FP(1), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .SYNC_POL(1'b1), .CLK_DIV(1)
    ) u_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

    // ---------------- helpers ----------------
    function automatic obs_t mk(input int hp, input int ln, input logic va, input logic hs,
                                input logic vs, input logic fs, input logic pe);
        obs_t o;
        o.hp = 32'(hp);
        o.ln = 32'(ln);
        o.va = va;
        o.hs = hs;
        o.vs = vs;
        o.fs = fs;
        o.pe = pe;
        return o;
    endfunction

    // Reference model: k is the number of clks elapsed since the counters
    // were last cleared; the outputs shown at an edge describe that instant.
    function automatic obs_t model_out(input cfg_t c, input int k, input bit r);
        obs_t o;
        int ht, vt, p, hp, ln;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        p  = k / c.div;
        hp = p % ht;
        ln = (p / ht) % vt;
        o.hp = 32'(hp);
        o.ln = 32'(ln);
        o.va = (hp < c.ha) && (ln < c.va);
        o.hs = (hp >= c.ha + c.hfp && hp < c.ha + c.hfp + c.hsw) ? c.pol : ~c.pol;
        o.vs = (ln >= c.va + c.vfp && ln < c.va + c.vfp + c.vsw) ? c.pol : ~c.pol;
        o.fs = ((k % (c.div * ht * vt)) == 0) && !r;
        o.pe = ((k % c.div) == c.div - 1);
        return o;
    endfunction

    function automatic obs_t reset_out(input cfg_t c);
        return mk(0, 0, 1'b0, ~c.pol, ~c.pol, 1'b0, 1'b0);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got hp=%0d ln=%0d va=%b hs=%b vs=%b fs=%b pe=%b, expected hp=%0d ln=%0d va=%b hs=%b vs=%b fs=%b pe=%b",
                      name, got.hp, got.ln, got.va, got.hs, got.vs, got.fs, got.pe,
                      exp.hp, exp.ln, exp.va, exp.hs, exp.vs, exp.fs, exp.pe);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Per-cycle monitor: samples all three instances after each edge and
    // compares against the model, advancing each model clock.
    always @(posedge clk) begin
        bit   r [3];
        obs_t e;
        r[0] = if_def.restart;
        r[1] = if_b.restart;
        r[2] = if_c.restart;
        #1;
        act[0] = mk(if_def.hPixel, if_def.line, if_def.video_active, if_def.hSync, if_def.vSync, if_def.frame_start, if_def.pix_en);
        act[1] = mk(if_b.hPixel, if_b.line, if_b.video_active, if_b.hSync, if_b.vSync, if_b.frame_start, if_b.pix_en);
        act[2] = mk(if_c.hPixel, if_c.line, if_c.video_active, if_c.hSync, if_c.vSync, if_c.frame_start, if_c.pix_en);
        for (int d = 0; d < 3; d++) begin
            if (!reset_n) begin
                e = reset_out(cfg[d]);
                k_cnt[d] = 0;
            end else begin
                e = model_out(cfg[d], k_cnt[d], r[d]);
                k_cnt[d] = r[d] ? 0 : k_cnt[d] + 1;
            end
            check_obs($sformatf("mon%0d_k%0d", d, k_cnt[d]), act[d], e);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_edge();
        @(posedge clk);
        #2;
    endtask

    // Wait for a frame_start, then measure the frame period and count the
    // clks with each sync asserted over that one frame.
    task automatic measure_frame(input int d, input int period, input int hs_act, input int vs_act,
                                 input logic pol, input string name);
        bit got;
        int n, hs_n, vs_n;
        got = 0;
        for (int i = 0; i < 2 * period + 4 && !got; i++) begin
            next_edge();
            if (act[d].fs) got = 1;
        end
        check_int({name, "_fs_found"}, int'(got), 1);
        if (got) begin
            n    = 0;
            hs_n = (act[d].hs == pol) ? 1 : 0;
            vs_n = (act[d].vs == pol) ? 1 : 0;
            got  = 0;
            for (int i = 0; i < period + 4 && !got; i++) begin
                next_edge();
                n++;
                if (act[d].fs) got = 1;
                else begin
                    if (act[d].hs == pol) hs_n++;
                    if (act[d].vs == pol) vs_n++;
                end
            end
            check_int({name, "_period"}, n, period);
            check_int({name, "_hsync_clks"}, hs_n, hs_act);
            check_int({name, "_vsync_clks"}, vs_n, vs_act);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t tbl [$];
        vec_t v;
        int   cnt, hs_low, va_hi, fs_n;
        bit   found;

        if_def.restart = 1'b0;
        if_b.restart   = 1'b0;
        if_c.restart   = 1'b0;
        cfg[0] = '{ha: 640, hfp: 16, hsw: 96, hbp: 48, va: 480, vfp: 10, vsw: 2, vbp: 33, pol: 1'b0, div: 2};
        cfg[1] = '{ha: 8, hfp: 2, hsw: 3, hbp: 2, va: 4, vfp: 1, vsw: 2, vbp: 1, pol: 1'b0, div: 3};
        cfg[2] = '{ha: 6, hfp: 1, hsw: 4, hbp: 2, va: 3, vfp: 1, vsw: 1, vbp: 2, pol: 1'b1, div: 1};

        // Default-timing vectors: edge index after reset release -> outputs.
        tbl.push_back('{"first_edge",   0,    mk(0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0)});
        tbl.push_back('{"first_pix_en", 1,    mk(0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1)});
        tbl.push_back('{"pixel_1",      2,    mk(1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)});
        tbl.push_back('{"last_active",  1279, mk(639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1)});
        tbl.push_back('{"blank_start",  1280, mk(640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)});
        tbl.push_back('{"pre_hsync",    1311, mk(655, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1)});
        tbl.push_back('{"hsync_start",  1312, mk(656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)});
        tbl.push_back('{"hsync_last",   1503, mk(751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)});
        tbl.push_back('{"hsync_end",    1504, mk(752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)});
        tbl.push_back('{"line_end",     1599, mk(799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1)});
        tbl.push_back('{"line_wrap",    1600, mk(0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)});

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_obs("reset_def", act[0], mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        check_obs("reset_c",   act[2], mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        reset_n = 1'b1;
        cnt = -1;
        foreach (tbl[i]) begin
            v = tbl[i];
            while (cnt < v.k) begin
                next_edge();
                cnt++;
            end
            check_obs(v.name, act[0], v.exp);
        end

        // Whole of line 1: hsync width and visible width in clks.
        hs_low = (act[0].hs == 1'b0) ? 1 : 0;
        va_hi  = act[0].va ? 1 : 0;
        while (cnt < 3199) begin
            next_edge();
            cnt++;
            if (act[0].hs == 1'b0) hs_low++;
            if (act[0].va) va_hi++;
        end
        check_int("hsync_low_clks", hs_low, 192);
        check_int("active_clks",    va_hi,  1280);
        check_int("line1_last_hp",  int'(act[0].hp), 799);
        next_edge();
        check_obs("line2_start", act[0], mk(0, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));

        // Restart at hPixel=300 (first clk of that pixel).
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            next_edge();
            if (act[0].hp == 32'd300 && act[0].pe == 1'b0) found = 1;
        end
        check_int("restart_seek", int'(found), 1);
        @(negedge clk) if_def.restart = 1'b1;
        next_edge();
        check_int("restart_edge_hp", int'(act[0].hp), 300);
        @(negedge clk) if_def.restart = 1'b0;
        next_edge();
        check_obs("restart_first",  act[0], mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
        next_edge();
        check_obs("restart_second", act[0], mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));

        // Restart held for four edges: counters pinned, no frame_start.
        @(negedge clk) if_def.restart = 1'b1;
        next_edge();
        check_obs("hold_0", act[0], mk(1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 1; i < 4; i++) begin
            next_edge();
            check_obs($sformatf("hold_%0d", i), act[0], mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        end
        @(negedge clk) if_def.restart = 1'b0;
        next_edge();
        check_obs("hold_release", act[0], mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
        fs_n = 1;
        for (int i = 0; i < 6; i++) begin
            next_edge();
            if (act[0].fs) fs_n++;
        end
        check_int("hold_release_pulses", fs_n, 1);

        // Random restart pulses on all instances, checked by the monitor.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if_def.restart = ($urandom_range(0, 99) < 2);
            if_b.restart   = ($urandom_range(0, 99) < 3);
            if_c.restart   = ($urandom_range(0, 99) < 3);
        end
        @(negedge clk);
        if_def.restart = 1'b0;
        if_b.restart   = 1'b0;
        if_c.restart   = 1'b0;

        // Full frames on the small rasters (period, sync clks per frame).
        measure_frame(1, 360, 72, 90, 1'b0, "frame_b");
        measure_frame(2, 91,  28, 13, 1'b1, "frame_c");

        // Asynchronous reset mid-line, between clk edges.
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_obs("async_reset_def",
                  mk(if_def.hPixel, if_def.line, if_def.video_active, if_def.hSync, if_def.vSync, if_def.frame_start, if_def.pix_en),
                  mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        check_obs("async_reset_c",
                  mk(if_c.hPixel, if_c.line, if_c.video_active, if_c.hSync, if_c.vSync, if_c.frame_start, if_c.pix_en),
                  mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        next_edge();
        check_obs("rerelease_first",  act[0], mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
        check_obs("rerelease_c",      act[2], mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        next_edge();
        check_obs("rerelease_second", act[0], mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
        repeat (4) next_edge();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
